ex_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline. It consumes the ID/EX pipeline-register outputs and decodes ALU control from `ctrl_aluOp` and funct. It computes the ALU result, zero flag, branch target and destination register, and registers them, together with the MEM/WB controls, into the EX/MEM boundary. It also contains a 32-cycle unsigned multiplier (`multu`) with HI/LO registers, and raises a stall interlock when a dependent instruction reaches EX while the multiply is in progress.

---
 rtl/mips_pkg.sv | 63 ++++++
 rtl/multu_unit.sv | 73 +++++++
 rtl/ex_stage.sv | 127 ++++++++++++
 tb/tb_ex_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and ALU control decode for the EX stage
package mips_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT,
        ALU_MFHI,
        ALU_MFLO,
        ALU_MULTU
    } alu_ctrl_t;

    typedef enum logic {
        MULT_IDLE,
        MULT_BUSY
    } mult_state_t;

    // The reserved aluOp 11 and unknown functs fall back to add.
    function automatic alu_ctrl_t decode_alu(input logic [1:0] alu_op, input logic [5:0] funct);
        alu_ctrl_t ctrl;
        ctrl = ALU_ADD;
        if (alu_op == ALUOP_SUB) begin
            ctrl = ALU_SUB;
        end else if (alu_op == ALUOP_RTYPE) begin
            case (funct)
                FUNCT_SUB:   ctrl = ALU_SUB;
                FUNCT_AND:   ctrl = ALU_AND;
                FUNCT_OR:    ctrl = ALU_OR;
                FUNCT_NOR:   ctrl = ALU_NOR;
                FUNCT_SLT:   ctrl = ALU_SLT;
                FUNCT_MFHI:  ctrl = ALU_MFHI;
                FUNCT_MFLO:  ctrl = ALU_MFLO;
                FUNCT_MULTU: ctrl = ALU_MULTU;
                default:     ctrl = ALU_ADD;
            endcase
        end
        return ctrl;
    endfunction

    // Instructions that must wait for HI/LO or for the multiplier to free up.
    function automatic logic is_mult_dependent(input logic [1:0] alu_op, input logic [5:0] funct);
        return (alu_op == ALUOP_RTYPE) &&
               ((funct == FUNCT_MFHI) || (funct == FUNCT_MFLO) || (funct == FUNCT_MULTU));
    endfunction

endpackage

// File: rtl/multu_unit.sv
// rtl/multu_unit.sv - 32-cycle unsigned shift-add multiplier with HI/LO registers
module multu_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mult_state_t state;
    mult_state_t state_next;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc_sum;

    // One partial product per cycle: add the shifted multiplicand when the current multiplier bit is set.
    assign acc_sum = acc + (mplier[0] ? mcand : 64'd0);
    assign busy    = (state == MULT_BUSY);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MULT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: launch from IDLE, return after the 32nd partial product.
    always_comb begin
        state_next = state;
        case (state)
            MULT_IDLE: if (start) state_next = MULT_BUSY;
            MULT_BUSY: if (count == 5'd31) state_next = MULT_IDLE;
            default:   state_next = MULT_IDLE;
        endcase
    end

    // Datapath: operand capture on launch, shift-add while busy, HI/LO written on the last step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= 5'd0;
            acc    <= 64'd0;
            mcand  <= 64'd0;
            mplier <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else if (state == MULT_IDLE) begin
            if (start) begin
                count  <= 5'd0;
                acc    <= 64'd0;
                mcand  <= {32'd0, a};
                mplier <= b;
            end
        end else begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
            if (count == 5'd31) begin
                {hi, lo} <= acc_sum;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ALU, branch adder, multu interlock and EX/MEM register
module ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        ctrl_regWrite_id_ex,
    input  logic        ctrl_memToReg_id_ex,
    input  logic        ctrl_branch_id_ex,
    input  logic        ctrl_memRead_id_ex,
    input  logic        ctrl_memWrite_id_ex,
    input  logic        ctrl_regDest_id_ex,
    input  logic        ctrl_aluSrc_id_ex,
    input  logic [1:0]  ctrl_aluOp_id_ex,
    input  logic [31:0] supposed_next_address_id_ex,
    input  logic [31:0] read_data_1_id_ex,
    input  logic [31:0] read_data_2_id_ex,
    input  logic [31:0] extended_branch_offset_id_ex,
    input  logic [31:0] next_instruction_20_16_id_ex,
    input  logic [31:0] next_instruction_15_11_id_ex,
    output logic        stall_ex,
    output logic        ctrl_regWrite_ex_mem,
    output logic        ctrl_memToReg_ex_mem,
    output logic        ctrl_branch_ex_mem,
    output logic        ctrl_memRead_ex_mem,
    output logic        ctrl_memWrite_ex_mem,
    output logic [31:0] branch_address_ex_mem,
    output logic        zero_ex_mem,
    output logic [31:0] alu_result_ex_mem,
    output logic [31:0] read_data_2_ex_mem,
    output logic [4:0]  write_register_ex_mem
);

    logic [5:0]  funct;
    alu_ctrl_t   alu_ctrl;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] alu_result;
    logic [31:0] branch_address;
    logic [4:0]  write_register;
    logic        is_multu;
    logic        bubble;
    logic        mult_start;
    logic        mult_busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        unused_reg_bits;

    assign funct     = extended_branch_offset_id_ex[5:0];
    assign alu_ctrl  = decode_alu(ctrl_aluOp_id_ex, funct);
    assign operand_a = read_data_1_id_ex;
    assign operand_b = ctrl_aluSrc_id_ex ? extended_branch_offset_id_ex : read_data_2_id_ex;
    assign is_multu  = (alu_ctrl == ALU_MULTU);

    // Register indices arrive as 32-bit fields; only the low five bits name a register.
    assign unused_reg_bits = ^{next_instruction_20_16_id_ex[31:5], next_instruction_15_11_id_ex[31:5]};
    assign write_register  = ctrl_regDest_id_ex ? next_instruction_15_11_id_ex[4:0]
                                                : next_instruction_20_16_id_ex[4:0];
    assign branch_address  = supposed_next_address_id_ex + {extended_branch_offset_id_ex[29:0], 2'b00};

    // A stalled multu is not launched; it relaunches once the multiplier is idle again.
    assign stall_ex   = mult_busy & is_mult_dependent(ctrl_aluOp_id_ex, funct);
    assign bubble     = stall_ex | flush;
    assign mult_start = is_multu & ~bubble;

    multu_unit u_multu (
        .clk   (clk),
        .reset (reset),
        .start (mult_start),
        .a     (operand_a),
        .b     (operand_b),
        .busy  (mult_busy),
        .hi    (hi),
        .lo    (lo)
    );

    // ALU: modulo-2^32 arithmetic, signed slt, HI/LO moves.
    always_comb begin
        alu_result = operand_a + operand_b;
        case (alu_ctrl)
            ALU_ADD:  alu_result = operand_a + operand_b;
            ALU_SUB:  alu_result = operand_a - operand_b;
            ALU_AND:  alu_result = operand_a & operand_b;
            ALU_OR:   alu_result = operand_a | operand_b;
            ALU_NOR:  alu_result = ~(operand_a | operand_b);
            ALU_SLT:  alu_result = {31'd0, ($signed(operand_a) < $signed(operand_b))};
            ALU_MFHI: alu_result = hi;
            ALU_MFLO: alu_result = lo;
            default:  alu_result = operand_a + operand_b;
        endcase
    end

    // EX/MEM register: a bubble clears the controls and holds the data fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_regWrite_ex_mem  <= 1'b0;
            ctrl_memToReg_ex_mem  <= 1'b0;
            ctrl_branch_ex_mem    <= 1'b0;
            ctrl_memRead_ex_mem   <= 1'b0;
            ctrl_memWrite_ex_mem  <= 1'b0;
            branch_address_ex_mem <= 32'd0;
            zero_ex_mem           <= 1'b0;
            alu_result_ex_mem     <= 32'd0;
            read_data_2_ex_mem    <= 32'd0;
            write_register_ex_mem <= 5'd0;
        end else if (bubble) begin
            ctrl_regWrite_ex_mem  <= 1'b0;
            ctrl_memToReg_ex_mem  <= 1'b0;
            ctrl_branch_ex_mem    <= 1'b0;
            ctrl_memRead_ex_mem   <= 1'b0;
            ctrl_memWrite_ex_mem  <= 1'b0;
        end else begin
            ctrl_regWrite_ex_mem  <= ctrl_regWrite_id_ex & ~is_multu;
            ctrl_memToReg_ex_mem  <= ctrl_memToReg_id_ex;
            ctrl_branch_ex_mem    <= ctrl_branch_id_ex;
            ctrl_memRead_ex_mem   <= ctrl_memRead_id_ex;
            ctrl_memWrite_ex_mem  <= ctrl_memWrite_id_ex & ~is_multu;
            branch_address_ex_mem <= branch_address;
            zero_ex_mem           <= (alu_result == 32'd0);
            alu_result_ex_mem     <= alu_result;
            read_data_2_ex_mem    <= read_data_2_id_ex;
            write_register_ex_mem <= write_register;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage with directed vectors
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        rw_in, mtr_in, br_in, mr_in, mw_in, rdst_in, src_in;
    logic [1:0]  op_in;
    logic [31:0] pc4_in, a_in, b_in, off_in, rt_in, rd_in;
    logic        stall_ex;
    logic        rw_out, mtr_out, br_out, mr_out, mw_out;
    logic [31:0] ba_out;
    logic        zero_out;
    logic [31:0] res_out;
    logic [31:0] rd2_out;
    logic [4:0]  wr_out;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk                          (clk),
        .reset                        (reset),
        .flush                        (flush),
        .ctrl_regWrite_id_ex          (rw_in),
        .ctrl_memToReg_id_ex          (mtr_in),
        .ctrl_branch_id_ex            (br_in),
        .ctrl_memRead_id_ex           (mr_in),
        .ctrl_memWrite_id_ex          (mw_in),
        .ctrl_regDest_id_ex           (rdst_in),
        .ctrl_aluSrc_id_ex            (src_in),
        .ctrl_aluOp_id_ex             (op_in),
        .supposed_next_address_id_ex  (pc4_in),
        .read_data_1_id_ex            (a_in),
        .read_data_2_id_ex            (b_in),
        .extended_branch_offset_id_ex (off_in),
        .next_instruction_20_16_id_ex (rt_in),
        .next_instruction_15_11_id_ex (rd_in),
        .stall_ex                     (stall_ex),
        .ctrl_regWrite_ex_mem         (rw_out),
        .ctrl_memToReg_ex_mem         (mtr_out),
        .ctrl_branch_ex_mem           (br_out),
        .ctrl_memRead_ex_mem          (mr_out),
        .ctrl_memWrite_ex_mem         (mw_out),
        .branch_address_ex_mem        (ba_out),
        .zero_ex_mem                  (zero_out),
        .alu_result_ex_mem            (res_out),
        .read_data_2_ex_mem           (rd2_out),
        .write_register_ex_mem        (wr_out)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, off, pc4;
        logic [4:0]  rt, rd;
        logic        rw, mtr, br, mr, mw, rdst, src, fl;
    } instr_t;

    typedef struct {
        string       name;
        logic [4:0]  ctrl;
        bit          chk;
        logic [31:0] res;
        logic        zero;
        logic [31:0] ba, rd2;
        logic [4:0]  wr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   model_busy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic instr_t rtype(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                                     input logic [4:0] rt, input logic [4:0] rd);
        instr_t i;
        i = '{default: '0};
        i.op = 2'b10; i.a = a; i.b = b; i.off = {26'd0, f}; i.pc4 = 32'h40;
        i.rt = rt; i.rd = rd; i.rw = 1'b1; i.rdst = 1'b1;
        return i;
    endfunction

    function automatic exp_t ex(input string n, input logic [4:0] c, input logic [31:0] r, input logic z,
                                input logic [31:0] ba, input logic [31:0] rd2, input logic [4:0] wr);
        exp_t e;
        e.name = n; e.ctrl = c; e.chk = 1'b1; e.res = r; e.zero = z; e.ba = ba; e.rd2 = rd2; e.wr = wr;
        return e;
    endfunction

    task automatic set_in(input instr_t i);
        op_in = i.op; a_in = i.a; b_in = i.b; off_in = i.off; pc4_in = i.pc4;
        rt_in = {27'd0, i.rt}; rd_in = {27'd0, i.rd};
        rw_in = i.rw; mtr_in = i.mtr; br_in = i.br; mr_in = i.mr; mw_in = i.mw;
        rdst_in = i.rdst; src_in = i.src; flush = i.fl;
    endtask

    // Drive one instruction, holding it while the model says it is stalled; push one expectation per edge.
    task automatic issue(input instr_t i, input exp_t e, input int exp_stalls);
        int   stalls;
        bit   dep, is_mul, es, launched;
        exp_t bub;
        stalls = 0;
        dep    = (i.op == 2'b10) && (i.off[5:0] inside {6'h10, 6'h12, 6'h19});
        is_mul = (i.op == 2'b10) && (i.off[5:0] == 6'h19);
        bub    = ex({e.name, " bubble"}, 5'b00000, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0);
        bub.chk = 1'b0;
        @(negedge clk);
        set_in(i);
        for (int k = 0; k < 40; k++) begin
            es = (model_busy > 0) && dep;
            #1;
            chk({e.name, " stall_ex"}, {63'd0, stall_ex}, {63'd0, es});
            if (es || i.fl) exp_q.push_back(bub);
            else            exp_q.push_back(e);
            launched = is_mul && !es && !i.fl;
            @(posedge clk);
            if (model_busy > 0) model_busy--;
            if (launched) model_busy = 32;
            if (!es || i.fl) break;
            stalls++;
            @(negedge clk);
        end
        chk({e.name, " stall_cycles"}, 64'(stalls), 64'(exp_stalls));
    endtask

    task automatic check_reset(input string n);
        chk({n, " ctrl"}, {59'd0, rw_out, mtr_out, br_out, mr_out, mw_out}, 64'd0);
        chk({n, " branch_address"}, {32'd0, ba_out}, 64'd0);
        chk({n, " alu_result"}, {32'd0, res_out}, 64'd0);
        chk({n, " read_data_2"}, {32'd0, rd2_out}, 64'd0);
        chk({n, " zero_wr"}, {58'd0, zero_out, wr_out}, 64'd0);
        chk({n, " stall_ex"}, {63'd0, stall_ex}, 64'd0);
    endtask

    // Monitor: after every edge, pop the next expectation and compare against the EX/MEM outputs.
    initial begin
        forever begin : mon
            exp_t e;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, " ctrl"}, {59'd0, rw_out, mtr_out, br_out, mr_out, mw_out}, {59'd0, e.ctrl});
                if (e.chk) begin
                    chk({e.name, " alu_result"}, {32'd0, res_out}, {32'd0, e.res});
                    chk({e.name, " zero"}, {63'd0, zero_out}, {63'd0, e.zero});
                    chk({e.name, " branch_address"}, {32'd0, ba_out}, {32'd0, e.ba});
                    chk({e.name, " read_data_2"}, {32'd0, rd2_out}, {32'd0, e.rd2});
                    chk({e.name, " write_register"}, {59'd0, wr_out}, {59'd0, e.wr});
                end
            end
        end
    end

    initial begin
        instr_t i;
        exp_t   e;
        reset = 1'b0;
        i = '{default: '0};
        set_in(i);
        repeat (2) @(negedge clk);
        check_reset("reset_init");
        reset = 1'b1;

        issue(rtype(32'd5, 32'd5, 6'h22, 5'd3, 5'd7), ex("sub", 5'b10000, 32'd0, 1'b1, 32'hC8, 32'd5, 5'd7), 0);
        issue(rtype(32'hFFFFFFFF, 32'd1, 6'h2A, 5'd4, 5'd8), ex("slt", 5'b10000, 32'd1, 1'b0, 32'hE8, 32'd1, 5'd8), 0);
        issue(rtype(32'hF0F000FF, 32'h0FF00F0F, 6'h24, 5'd1, 5'd9),
              ex("and", 5'b10000, 32'h00F0000F, 1'b0, 32'hD0, 32'h0FF00F0F, 5'd9), 0);
        issue(rtype(32'hF0F000FF, 32'h0FF00F0F, 6'h25, 5'd1, 5'd9),
              ex("or", 5'b10000, 32'hFFF00FFF, 1'b0, 32'hD4, 32'h0FF00F0F, 5'd9), 0);
        issue(rtype(32'hF0F000FF, 32'h0FF00F0F, 6'h27, 5'd1, 5'd9),
              ex("nor", 5'b10000, 32'h000FF000, 1'b0, 32'hDC, 32'h0FF00F0F, 5'd9), 0);
        issue(rtype(32'd7, 32'd8, 6'h03, 5'd1, 5'd12), ex("funct_default", 5'b10000, 32'd15, 1'b0, 32'h4C, 32'd8, 5'd12), 0);

        i = rtype(32'd3, 32'd3, 6'h00, 5'd2, 5'd0);
        i.op = 2'b01; i.rw = 1'b0; i.br = 1'b1; i.rdst = 1'b0; i.off = 32'hFFFFFFFF; i.pc4 = 32'h100;
        issue(i, ex("branch", 5'b00100, 32'd0, 1'b1, 32'hFC, 32'd3, 5'd2), 0);

        i = rtype(32'h1000, 32'hDEAD, 6'h00, 5'd5, 5'd0);
        i.op = 2'b00; i.src = 1'b1; i.rdst = 1'b0; i.mtr = 1'b1; i.mr = 1'b1; i.off = 32'h10;
        issue(i, ex("lw", 5'b11010, 32'h1010, 1'b0, 32'h80, 32'hDEAD, 5'd5), 0);

        i = rtype(32'h2000, 32'h1234, 6'h00, 5'd6, 5'd0);
        i.op = 2'b00; i.src = 1'b1; i.rdst = 1'b0; i.rw = 1'b0; i.mw = 1'b1; i.off = 32'hFFFFFFFC;
        issue(i, ex("sw", 5'b00001, 32'h1FFC, 1'b0, 32'h30, 32'h1234, 5'd6), 0);

        i = rtype(32'd1, 32'd2, 6'h00, 5'd13, 5'd0);
        i.op = 2'b01; i.rw = 1'b0; i.br = 1'b1; i.rdst = 1'b0;
        issue(i, ex("sub_op01", 5'b00100, 32'hFFFFFFFF, 1'b0, 32'h40, 32'd2, 5'd13), 0);

        // multu then mflo/mfhi; regWrite and memWrite requested but must be suppressed
        i = rtype(32'hFFFFFFFF, 32'd2, 6'h19, 5'd0, 5'd0);
        i.mw = 1'b1;
        e = ex("multu", 5'b00000, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0);
        e.chk = 1'b0;
        issue(i, e, 0);
        issue(rtype(32'd0, 32'd0, 6'h12, 5'd0, 5'd10), ex("mflo", 5'b10000, 32'hFFFFFFFE, 1'b0, 32'h88, 32'd0, 5'd10), 32);
        issue(rtype(32'd0, 32'd0, 6'h10, 5'd0, 5'd10), ex("mfhi", 5'b10000, 32'd1, 1'b0, 32'h80, 32'd0, 5'd10), 0);

        // flushed multu must not launch
        i = rtype(32'd5, 32'd5, 6'h19, 5'd0, 5'd0);
        i.fl = 1'b1;
        e.name = "multu_flush";
        issue(i, e, 0);
        issue(rtype(32'd0, 32'd0, 6'h12, 5'd0, 5'd10),
              ex("mflo_after_flush", 5'b10000, 32'hFFFFFFFE, 1'b0, 32'h88, 32'd0, 5'd10), 0);

        // independent instruction during BUSY, then back-to-back multu
        e.name = "multu_a";
        issue(rtype(32'h10000, 32'h10000, 6'h19, 5'd0, 5'd0), e, 0);
        issue(rtype(32'd2, 32'd3, 6'h20, 5'd1, 5'd11), ex("add_during_busy", 5'b10000, 32'd5, 1'b0, 32'hC0, 32'd3, 5'd11), 0);
        e.name = "multu_b";
        issue(rtype(32'd3, 32'd5, 6'h19, 5'd0, 5'd0), e, 31);
        issue(rtype(32'd0, 32'd0, 6'h12, 5'd0, 5'd10), ex("mflo_second", 5'b10000, 32'd15, 1'b0, 32'h88, 32'd0, 5'd10), 32);
        issue(rtype(32'd0, 32'd0, 6'h10, 5'd0, 5'd10), ex("mfhi_second", 5'b10000, 32'd0, 1'b1, 32'h80, 32'd0, 5'd10), 0);

        // stall and flush together: bubble, multiplier keeps running
        e.name = "multu_c";
        issue(rtype(32'd7, 32'd6, 6'h19, 5'd0, 5'd0), e, 0);
        i = rtype(32'd0, 32'd0, 6'h12, 5'd0, 5'd10);
        i.fl = 1'b1;
        issue(i, ex("mflo_stall_flush", 5'b10000, 32'd0, 1'b0, 32'h88, 32'd0, 5'd10), 0);
        issue(rtype(32'd0, 32'd0, 6'h12, 5'd0, 5'd10), ex("mflo_third", 5'b10000, 32'd42, 1'b0, 32'h88, 32'd0, 5'd10), 31);

        // reset in the middle of a multiply
        e.name = "multu_d";
        issue(rtype(32'hFFFFFFFF, 32'hFFFFFFFF, 6'h19, 5'd0, 5'd0), e, 0);
        issue(rtype(32'd1, 32'd1, 6'h20, 5'd1, 5'd14), ex("add_busy_1", 5'b10000, 32'd2, 1'b0, 32'hC0, 32'd1, 5'd14), 0);
        issue(rtype(32'd2, 32'd2, 6'h20, 5'd1, 5'd15), ex("add_busy_2", 5'b10000, 32'd4, 1'b0, 32'hC0, 32'd2, 5'd15), 0);
        @(negedge clk);
        set_in(rtype(32'd0, 32'd0, 6'h12, 5'd0, 5'd10));
        reset = 1'b0;
        model_busy = 0;
        #1;
        check_reset("reset_mid");
        @(negedge clk);
        reset = 1'b1;
        issue(rtype(32'd0, 32'd0, 6'h10, 5'd0, 5'd10), ex("mfhi_after_reset", 5'b10000, 32'd0, 1'b1, 32'h80, 32'd0, 5'd10), 0);
        issue(rtype(32'd0, 32'd0, 6'h12, 5'd0, 5'd10), ex("mflo_after_reset", 5'b10000, 32'd0, 1'b1, 32'h88, 32'd0, 5'd10), 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
